// File: rtl/vga_timing_gen.sv
// Parametrised video sync generator with a pixel clock-enable, aligned line/frame strobes
// and a completed-frame counter. Every output is registered from the pre-increment counters.
module vga_timing_gen #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_DISP  = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_DISP  = 480,
  parameter int V_FRONT = 10,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int CW      = 10,
  parameter int FRAME_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [CW-1:0]      x,
  output logic [CW-1:0]      y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL     = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL     = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int H_ACT_START = H_SYNC + H_BACK;
  localparam int H_ACT_END   = H_ACT_START + H_DISP;
  localparam int V_ACT_START = V_SYNC + V_BACK;
  localparam int V_ACT_END   = V_ACT_START + V_DISP;

  logic [CW-1:0]      h_cnt_reg, h_cnt_next;
  logic [CW-1:0]      v_cnt_reg, v_cnt_next;
  logic [FRAME_W-1:0] frame_int_reg, frame_int_next;
  logic [31:0]        h_w, v_w;
  logic               h_last, v_last, h_act, v_act;

  logic               hsync_reg, hsync_next;
  logic               vsync_reg, vsync_next;
  logic               de_reg, de_next;
  logic [CW-1:0]      x_reg, x_next;
  logic [CW-1:0]      y_reg, y_next;
  logic               line_start_reg, line_start_next;
  logic               frame_start_reg, frame_start_next;
  logic [FRAME_W-1:0] frame_cnt_reg;

  // Decode in 32 bits so region bounds equal to 2^CW still compare correctly.
  assign h_w    = 32'(h_cnt_reg);
  assign v_w    = 32'(v_cnt_reg);
  assign h_last = (h_w == 32'(H_TOTAL - 1));
  assign v_last = (v_w == 32'(V_TOTAL - 1));
  assign h_act  = (h_w >= 32'(H_ACT_START)) && (h_w < 32'(H_ACT_END));
  assign v_act  = (v_w >= 32'(V_ACT_START)) && (v_w < 32'(V_ACT_END));

  always_comb begin
    h_cnt_next     = h_cnt_reg + CW'(1);
    v_cnt_next     = v_cnt_reg;
    frame_int_next = frame_int_reg;
    if (h_last) begin
      h_cnt_next = '0;
      if (v_last) begin
        v_cnt_next     = '0;
        frame_int_next = frame_int_reg + FRAME_W'(1);
      end else begin
        v_cnt_next = v_cnt_reg + CW'(1);
      end
    end
  end

  always_comb begin
    hsync_next       = (h_w < 32'(H_SYNC)) ? HS_POL : ~HS_POL;
    vsync_next       = (v_w < 32'(V_SYNC)) ? VS_POL : ~VS_POL;
    de_next          = h_act && v_act;
    x_next           = '0;
    y_next           = '0;
    if (de_next) begin
      x_next = CW'(h_w - 32'(H_ACT_START));
      y_next = CW'(v_w - 32'(V_ACT_START));
    end
    line_start_next  = (h_cnt_reg == '0);
    frame_start_next = (h_cnt_reg == '0) && (v_cnt_reg == '0);
  end

  // frame_int_reg runs alongside the counters; frame_cnt lags it by one pixel so the
  // new count appears with the frame_start strobe of the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_reg       <= '0;
      v_cnt_reg       <= '0;
      frame_int_reg   <= '0;
      hsync_reg       <= ~HS_POL;
      vsync_reg       <= ~VS_POL;
      de_reg          <= 1'b0;
      x_reg           <= '0;
      y_reg           <= '0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_cnt_reg   <= '0;
    end else if (pix_en) begin
      h_cnt_reg       <= h_cnt_next;
      v_cnt_reg       <= v_cnt_next;
      frame_int_reg   <= frame_int_next;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      de_reg          <= de_next;
      x_reg           <= x_next;
      y_reg           <= y_next;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
      frame_cnt_reg   <= frame_int_reg;
    end else begin
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end
  end

  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign de          = de_reg;
  assign x           = x_reg;
  assign y           = y_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;
  assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing and a small-timing instance share stimulus;
// a pixel-index model predicts every output each clk, plus literal checks of key events.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic pix_en;
  always #5 clk = ~clk;

  logic       hs_d, vs_d, de_d, ls_d, fs_d;
  logic [9:0] x_d, y_d;
  logic [7:0] fc_d;
  logic       hs_s, vs_s, de_s, ls_s, fs_s;
  logic [9:0] x_s, y_s;
  logic [1:0] fc_s;

  vga_timing_gen u_dflt (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(hs_d), .vsync(vs_d), .de(de_d), .x(x_d), .y(y_d),
    .line_start(ls_d), .frame_start(fs_d), .frame_cnt(fc_d)
  );

  vga_timing_gen #(
    .H_SYNC(2), .H_BACK(1), .H_DISP(4), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_DISP(3), .V_FRONT(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(10), .FRAME_W(2)
  ) u_small (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(hs_s), .vsync(vs_s), .de(de_s), .x(x_s), .y(y_s),
    .line_start(ls_s), .frame_start(fs_s), .frame_cnt(fc_s)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic hs, vs, de, ls, fs;
    int   x, y, fc;
  } pix_t;

  // Outputs for the n-th pixel since reset, straight from the timing rules.
  function automatic pix_t model_pix(input longint n, input int hsy, input int hb, input int hd,
                                     input int hf, input int vsy, input int vb, input int vd,
                                     input int vf, input bit hp, input bit vp);
    pix_t r;
    int ht, vt, h, v;
    longint line;
    ht   = hsy + hb + hd + hf;
    vt   = vsy + vb + vd + vf;
    h    = int'(n % ht);
    line = n / ht;
    v    = int'(line % vt);
    r.hs = (h < hsy) ? hp : !hp;
    r.vs = (v < vsy) ? vp : !vp;
    r.de = (h >= hsy + hb) && (h < hsy + hb + hd) && (v >= vsy + vb) && (v < vsy + vb + vd);
    r.x  = r.de ? h - hsy - hb : 0;
    r.y  = r.de ? v - vsy - vb : 0;
    r.ls = (h == 0);
    r.fs = (h == 0) && (v == 0);
    r.fc = int'(line / vt);
    return r;
  endfunction

  function automatic pix_t rst_val(input bit hp, input bit vp);
    pix_t r;
    r.hs = !hp; r.vs = !vp; r.de = 1'b0; r.ls = 1'b0; r.fs = 1'b0;
    r.x = 0; r.y = 0; r.fc = 0;
    return r;
  endfunction

  pix_t   e_d, e_s;
  longint n_m   = 0;
  bit     armed = 1'b0;

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      n_m   = 0;
      e_d   = rst_val(1'b0, 1'b0);
      e_s   = rst_val(1'b1, 1'b1);
      armed = 1'b1;
    end else if (pix_en === 1'b1) begin
      e_d = model_pix(n_m, 96, 48, 640, 16, 2, 33, 480, 10, 1'b0, 1'b0);
      e_s = model_pix(n_m, 2, 1, 4, 1, 1, 1, 3, 1, 1'b1, 1'b1);
      n_m++;
    end else begin
      e_d.ls = 1'b0; e_d.fs = 1'b0;
      e_s.ls = 1'b0; e_s.fs = 1'b0;
    end
    #1;
    if (armed) begin
      check("model_dflt", 64'({hs_d, vs_d, de_d, x_d, y_d, ls_d, fs_d, fc_d}),
            64'({e_d.hs, e_d.vs, e_d.de, 10'(e_d.x), 10'(e_d.y), e_d.ls, e_d.fs, 8'(e_d.fc)}));
      check("model_small", 64'({hs_s, vs_s, de_s, x_s, y_s, ls_s, fs_s, fc_s}),
            64'({e_s.hs, e_s.vs, e_s.de, 10'(e_s.x), 10'(e_s.y), e_s.ls, e_s.fs, 2'(e_s.fc)}));
    end
  end

  initial begin
    int pe, hs_act, hs_rise, ls_prev, found, lowcnt;
    int last_fs, nfs, prev_fc, hs_cnt, vs_cnt, decnt;
    rst = 1'b1;
    pix_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hsync_d", 64'(hs_d), 1);
    check("rst_vsync_d", 64'(vs_d), 1);
    check("rst_de_d", 64'(de_d), 0);
    check("rst_fc_d", 64'(fc_d), 0);
    check("rst_hsync_s", 64'(hs_s), 0);
    check("rst_vsync_s", 64'(vs_s), 0);
    rst = 1'b0;

    // Default timing, pix_en every 4th clk.
    pe = 0; hs_act = 0; hs_rise = -1; ls_prev = -1;
    for (int c = 0; c < 4 * 1700; c++) begin
      pix_en = (c % 4 == 0);
      @(negedge clk);
      if (pix_en) begin
        pe++;
        if (pe == 1) begin
          check("first_hsync", 64'(hs_d), 0);
          check("first_vsync", 64'(vs_d), 0);
          check("first_line_start", 64'(ls_d), 1);
          check("first_frame_start", 64'(fs_d), 1);
        end
        if (hs_rise < 0) begin
          if (hs_d == 1'b0) hs_act++;
          else hs_rise = pe;
        end
        if (ls_d) begin
          if (ls_prev >= 0) check("line_start_gap", 64'(pe - ls_prev), 800);
          ls_prev = pe;
        end
      end else if (pe == 1 && c == 1) begin
        check("strobe_width", 64'({ls_d, fs_d}), 0);
      end
    end
    check("hsync_active_len", 64'(hs_act), 96);

    // Run continuously up to the first visible pixel.
    pix_en = 1'b1;
    found = 0;
    for (int c = 0; c < 40000 && found == 0; c++) begin
      @(negedge clk);
      pe++;
      if (de_d) found = 1;
    end
    check("de_seen", 64'(found), 1);
    check("de_first_h", 64'((pe - 1) % 800), 144);
    check("de_first_v", 64'((pe - 1) / 800), 35);
    check("de_first_xy", 64'({x_d, y_d}), 0);
    lowcnt = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      pe++;
      if (!de_d) lowcnt++;
    end
    check("de_low_per_line", 64'(lowcnt), 160);

    // Freeze mid-display.
    repeat (100) begin
      @(negedge clk);
      pe++;
    end
    check("pre_hold_x", 64'(x_d), 100);
    check("pre_hold_y", 64'(y_d), 1);
    pix_en = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check("hold_levels", 64'({hs_d, vs_d, de_d, x_d, y_d, fc_d}),
            64'({1'b1, 1'b1, 1'b1, 10'd100, 10'd1, 8'd0}));
      check("hold_strobes", 64'({ls_d, fs_d}), 0);
    end
    pix_en = 1'b1;
    @(negedge clk);
    pe++;
    check("after_hold_x", 64'(x_d), 101);

    // Reset mid-line at h_cnt=300 together with pix_en.
    for (int c = 0; c < 800 && (pe % 800) != 300; c++) begin
      @(negedge clk);
      pe++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_dflt", 64'({hs_d, vs_d, de_d, x_d, y_d, ls_d, fs_d, fc_d}),
          64'({1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 8'd0}));
    check("midrst_small", 64'({hs_s, vs_s, de_s, ls_s, fs_s, fc_s}), 0);
    rst = 1'b0;

    // Small timing, five frames at full rate.
    last_fs = -1; nfs = 0; prev_fc = -1; hs_cnt = 0; vs_cnt = 0; decnt = 0;
    for (int k = 1; k <= 240; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("post_rst_dflt", 64'({hs_d, vs_d, ls_d, fs_d}), 64'(4'b0011));
        check("post_rst_small", 64'({hs_s, vs_s, ls_s, fs_s}), 64'(4'b1111));
      end
      if (k <= 8 && hs_s) hs_cnt++;
      if (k <= 48 && vs_s) vs_cnt++;
      if (fs_s) begin
        if (last_fs > 0) check("frame_start_gap", 64'(k - last_fs), 48);
        check("frame_cnt_seq", 64'(fc_s), 64'(nfs % 4));
        if (k > 1) check("frame_cnt_before", 64'(prev_fc), 64'((nfs + 3) % 4));
        last_fs = k;
        nfs++;
      end
      if (de_s) begin
        check("small_x_seq", 64'(x_s), 64'(decnt % 4));
        check("small_y_seq", 64'(y_s), 64'((decnt / 4) % 3));
        decnt++;
      end
      prev_fc = int'(fc_s);
    end
    check("small_hsync_high", 64'(hs_cnt), 2);
    check("small_vsync_high", 64'(vs_cnt), 8);
    check("small_frames", 64'(nfs), 5);
    check("small_de_pixels", 64'(decnt), 60);

    // Random pix_en with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      pix_en = ($urandom_range(0, 2) != 0);
      rst    = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    pix_en = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
